// File: rtl/interdevice_uart_tx_pkg.sv
// Shared types for the inter-device UART: flit layout, default baud divisor
// and the transmitter state encoding.
package types;

    localparam int FLIT_BYTES        = 16;
    localparam int FLIT_W            = FLIT_BYTES * 8;
    localparam int UART_CLKS_PER_BIT = 868;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_e;

endpackage

// File: rtl/interdevice_uart_tx_baud_tick.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared between the transmitter and a future receiver.
module interdevice_uart_baud_tick
    import types::*;
#(
    parameter int CLKS_PER_BIT = types::UART_CLKS_PER_BIT
) (
    input  logic cpuclk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge cpuclk) begin
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/interdevice_uart_tx.sv
// Flit serializer: sends a 128-bit flit as 16 back-to-back 8N1 bytes,
// byte 0 (flit[7:0]) first, with a registered line output.
module interdevice_uart_tx
    import types::*;
#(
    parameter int CLKS_PER_BIT = types::UART_CLKS_PER_BIT
) (
    input  logic  cpuclk,
    input  logic  rst_n,
    input  flit_t flit_in,
    input  logic  flit_in_valid,
    output logic  flit_in_ready,
    output logic  uart_tx,
    output logic  busy
);

    localparam logic [3:0] LAST_BYTE = 4'(FLIT_BYTES - 1);
    localparam logic [2:0] LAST_BIT  = 3'd7;

    uart_tx_state_e r_state, w_state_next;
    flit_t          r_shift, w_shift_next;
    logic [3:0]     r_byte_cnt, w_byte_next;
    logic [2:0]     r_bit_cnt, w_bit_next;
    logic           r_tx, w_tx_next;
    logic           w_baud_clear;
    logic           w_tick;

    interdevice_uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .cpuclk(cpuclk),
        .rst_n (rst_n),
        .clear (w_baud_clear),
        .tick  (w_tick)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_byte_next  = r_byte_cnt;
        w_bit_next   = r_bit_cnt;
        w_tx_next    = r_tx;
        w_baud_clear = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_baud_clear = 1'b1;
                w_tx_next    = 1'b1;
                if (flit_in_valid) begin
                    w_state_next = ST_START;
                    w_shift_next = flit_in;
                    w_byte_next  = '0;
                    w_bit_next   = '0;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                end
            end
            ST_DATA: begin
                // The shift register moves one bit per data bit, so the next
                // byte is already at the bottom when its start bit begins.
                if (w_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = ST_STOP;
                        w_bit_next   = '0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_next   = r_bit_cnt + 3'd1;
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_state_next = ST_IDLE;
                        w_byte_next  = '0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_state_next = ST_START;
                        w_byte_next  = r_byte_cnt + 4'd1;
                        w_tx_next    = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // NOTE: the 128-bit shift register is cleared on reset too, so a frame
    // aborted mid-way leaves no stale data behind.
    always_ff @(posedge cpuclk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_byte_cnt <= w_byte_next;
            r_bit_cnt  <= w_bit_next;
            r_tx       <= w_tx_next;
        end
    end

    assign flit_in_ready = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign uart_tx       = r_tx;

endmodule

// File: tb/tb_interdevice_uart_tx.sv
// Self-checking bench: per-cycle line model built from byte framing rules,
// plus a UART decoder monitor and literal timing expectations.
module tb_interdevice_uart_tx;
    import types::*;

    localparam int CPB   = 4;
    localparam int FRAME = 160 * CPB;

    logic  cpuclk = 1'b0;
    logic  rst_n  = 1'b0;
    flit_t flit_in = '0;
    logic  flit_in_valid = 1'b0;
    logic  flit_in_ready;
    logic  uart_tx;
    logic  busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 cpuclk = ~cpuclk;

    interdevice_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .cpuclk       (cpuclk),
        .rst_n        (rst_n),
        .flit_in      (flit_in),
        .flit_in_valid(flit_in_valid),
        .flit_in_ready(flit_in_ready),
        .uart_tx      (uart_tx),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole frame is expanded into one expected line
    // level per clock cycle when a flit is accepted.
    logic exp_q[$];

    function automatic void push_frame(input flit_t f);
        logic [7:0] b;
        for (int i = 0; i < FLIT_BYTES; i++) begin
            b = f[8*i +: 8];
            repeat (CPB) exp_q.push_back(1'b0);
            for (int k = 0; k < 8; k++) repeat (CPB) exp_q.push_back(b[k]);
            repeat (CPB) exp_q.push_back(1'b1);
        end
    endfunction

    always @(posedge cpuclk) begin
        if (!rst_n)                exp_q.delete();
        else if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (flit_in_valid)    push_frame(flit_in);
    end

    always @(negedge cpuclk) begin
        if (chk_en) begin
            if (exp_q.size() != 0)
                check("line_tx_busy_ready", {uart_tx, busy, flit_in_ready}, {exp_q[0], 1'b1, 1'b0});
            else
                check("line_tx_busy_ready", {uart_tx, busy, flit_in_ready}, 3'b101);
        end
    end

    // Line decoder: samples each bit mid-way from the first low cycle.
    logic [7:0] dec_q[$];
    logic [7:0] dec_b;
    bit         dec_ok;

    initial begin
        forever begin
            @(negedge cpuclk);
            if (chk_en && rst_n && uart_tx == 1'b0) begin
                dec_ok = 1'b1;
                dec_b  = '0;
                for (int k = 1; k <= 38; k++) begin
                    @(negedge cpuclk);
                    if (!rst_n) dec_ok = 1'b0;
                    if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) dec_b[(k - 6) / 4] = uart_tx;
                end
                if (dec_ok) begin
                    check("stop_bit", uart_tx, 1'b1);
                    dec_q.push_back(dec_b);
                end
            end
        end
    end

    task automatic compare_bytes(input flit_t f, input int base);
        for (int i = 0; i < FLIT_BYTES; i++) begin
            if (base + i < dec_q.size()) check("decoded_byte", dec_q[base + i], f[8*i +: 8]);
            else check("decoded_byte_missing", base + i, dec_q.size());
        end
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 2000; t++) begin
            @(negedge cpuclk);
            if (busy === 1'b0) break;
        end
        check("idle_timeout", t < 2000, 1'b1);
        repeat (3) @(negedge cpuclk);
    endtask

    task automatic send_flit(input flit_t f);
        int t;
        flit_in       = f;
        flit_in_valid = 1'b1;
        for (t = 0; t < 2000; t++) begin
            if (flit_in_ready === 1'b1) break;
            @(negedge cpuclk);
        end
        check("accept_timeout", t < 2000, 1'b1);
        @(posedge cpuclk);
        #1;
        flit_in_valid = 1'b0;
        flit_in       = {4{$urandom}};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_t f1, fa, fb, fc, fd, fr;
        int    n;

        f1 = 128'h0F0E0D0C0B0A090807060504030201A5;

        // Reset held for two cycles.
        @(posedge cpuclk);
        #1 chk_en = 1'b1;
        @(posedge cpuclk);
        #1;
        check("reset_tx", uart_tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge cpuclk);
        check("reset_ready", flit_in_ready, 1'b1);

        // Single flit, input changed right after acceptance.
        flit_in       = f1;
        flit_in_valid = 1'b1;
        @(posedge cpuclk);
        #1;
        flit_in       = '1;
        flit_in_valid = 1'b0;
        n = 0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge cpuclk);
            if (busy !== 1'b1) break;
            if (n < 4) check("start_bit_low", uart_tx, 1'b0);
            if (n == 4) check("byte0_bit0", uart_tx, 1'b1);
            n++;
        end
        check("frame_len", n, FRAME);
        repeat (3) @(negedge cpuclk);
        check("single_byte_count", dec_q.size(), 16);
        if (dec_q.size() > 0) check("first_byte", dec_q[0], 8'hA5);
        compare_bytes(f1, 0);
        dec_q.delete();

        // Back-to-back flits with valid held high (also backpressure).
        fa = {4{$urandom}};
        fb = {4{$urandom}};
        flit_in       = fa;
        flit_in_valid = 1'b1;
        @(posedge cpuclk);
        #1 flit_in = fb;
        n = 0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge cpuclk);
            if (flit_in_ready === 1'b1) break;
            n++;
        end
        check("b2b_not_ready_cycles", n, FRAME);
        @(posedge cpuclk);
        #1 flit_in_valid = 1'b0;
        wait_idle();
        check("b2b_byte_count", dec_q.size(), 32);
        compare_bytes(fa, 0);
        compare_bytes(fb, 16);
        dec_q.delete();

        // Reset during byte 5, bit 3.
        fc = {4{$urandom}};
        send_flit(fc);
        repeat (218) @(negedge cpuclk);
        rst_n = 1'b0;
        @(posedge cpuclk);
        #1;
        check("midreset_tx", uart_tx, 1'b1);
        check("midreset_busy", busy, 1'b0);
        check("midreset_ready", flit_in_ready, 1'b1);
        @(negedge cpuclk);
        rst_n = 1'b1;
        repeat (50) @(negedge cpuclk);
        dec_q.delete();
        fd = {4{$urandom}};
        send_flit(fd);
        wait_idle();
        check("after_reset_byte_count", dec_q.size(), 16);
        compare_bytes(fd, 0);
        dec_q.delete();

        // Random flits with random idle gaps.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge cpuclk);
            fr = {4{$urandom}};
            send_flit(fr);
            wait_idle();
            check("rand_byte_count", dec_q.size(), 16);
            compare_bytes(fr, 0);
            dec_q.delete();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
